// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT sequencing controller.
// The LOAD phase is built only when FFT_SEQ_BITREV_EN is defined.
package fft_pkg;

   localparam int LOG2N_DEF = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_DRAIN,
      S_FIN
   } state_t;

   function automatic int stage_w(input int l);
      return (l > 1) ? $clog2(l) : 1;
   endfunction

   function automatic logic [31:0] bitreverse(
      input logic [31:0] v,
      input int          w
   );
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < w) r[i] = v[w-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Butterfly issue / write-back bundle between the sequencer
// and the butterfly datapath.
interface fft_seq_ctrl_if
   import fft_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEF
) ();

   localparam int SW = stage_w(LOG2N);

   logic             bf_valid;
   logic             bf_ready;
   logic [LOG2N-1:0] addr_a;
   logic [LOG2N-1:0] addr_b;
   logic [LOG2N-2:0] tw_idx;
   logic [SW-1:0]    stage;
   logic             wb_done;

   modport master (
      output bf_valid,
      output addr_a,
      output addr_b,
      output tw_idx,
      output stage,
      input  bf_ready,
      input  wb_done
   );

   modport slave (
      input  bf_valid,
      input  addr_a,
      input  addr_b,
      input  tw_idx,
      input  stage,
      output bf_ready,
      output wb_done
   );

endinterface

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT operand and twiddle address generator,
// purely combinational from (stage, butterfly index).
module fft_addr_gen
   import fft_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEF,
   parameter int SW    = stage_w(LOG2N)
) (
   input  logic [SW-1:0]    i_stage,
   input  logic [LOG2N-2:0] i_k,
   output logic [LOG2N-1:0] o_addr_a,
   output logic [LOG2N-1:0] o_addr_b,
   output logic [LOG2N-2:0] o_tw_idx
);

   logic [LOG2N-1:0] w_half;
   logic [LOG2N-1:0] w_kx;
   logic [LOG2N-1:0] w_pos;
   logic [LOG2N-1:0] w_grp;
   logic [LOG2N-1:0] w_tw;
   logic [SW-1:0]    w_sh;

   always_comb begin
      w_half   = LOG2N'(1) << i_stage;
      w_kx     = {1'b0, i_k};
      w_pos    = w_kx & (w_half - 1'b1);
      w_grp    = w_kx >> i_stage;
      w_sh     = SW'(LOG2N - 1) - i_stage;
      o_addr_a = ((w_grp << i_stage) << 1) | w_pos;
      o_addr_b = o_addr_a | w_half;
      // pos < half, so the shifted value always fits LOG2N-1 bits
      w_tw     = w_pos << w_sh;
      o_tw_idx = w_tw[LOG2N-2:0];
   end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Stage/butterfly sequencer for an in-place radix-2 FFT.
// Optional bit-reversed load phase: FFT_SEQ_BITREV_EN.
module fft_seq_ctrl
   import fft_pkg::*;
#(
   parameter int LOG2N   = LOG2N_DEF,
   parameter int MAX_OUT = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   output logic             Busy,
   output logic             Done,
   output logic             ld_valid,
   output logic [LOG2N-1:0] ld_addr,
   fft_seq_ctrl_if.master   bf
);

   localparam int KW = LOG2N - 1;
   localparam int SW = stage_w(LOG2N);
   localparam int CW = $clog2(MAX_OUT + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SW-1:0]    r_stage;
   logic [KW-1:0]    r_k;
   logic [CW-1:0]    r_out;
   logic             w_fire;
   logic             w_k_last;
   logic             w_s_last;
   logic             w_drained;
   logic             w_issue;
   logic [LOG2N-1:0] w_addr_a;
   logic [LOG2N-1:0] w_addr_b;
   logic [KW-1:0]    w_tw;

   assign w_issue   = r_state == S_ISSUE;
   assign w_fire    = bf.bf_valid & bf.bf_ready;
   assign w_k_last  = &r_k;
   assign w_s_last  = r_stage == SW'(LOG2N - 1);
   assign w_drained = r_out == '0;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

`ifdef FFT_SEQ_BITREV_EN
   logic [LOG2N-1:0] r_n;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)                r_n <= '0;
      else if (r_state == S_LOAD)  r_n <= r_n + 1'b1;
      else                         r_n <= '0;
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (Start) begin
`ifdef FFT_SEQ_BITREV_EN
               w_state_nxt = S_LOAD;
`else
               w_state_nxt = S_ISSUE;
`endif
            end
         end
`ifdef FFT_SEQ_BITREV_EN
         S_LOAD:  if (&r_n) w_state_nxt = S_ISSUE;
`endif
         S_ISSUE: if (w_fire && w_k_last) w_state_nxt = S_DRAIN;
         S_DRAIN: begin
            // stage barrier: every result of this stage is back
            if (w_drained)
               w_state_nxt = w_s_last ? S_FIN : S_ISSUE;
         end
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_stage <= '0;
         r_k     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_stage <= '0;
               r_k     <= '0;
            end
            S_ISSUE: if (w_fire) r_k <= r_k + 1'b1;
            S_DRAIN: begin
               if (w_drained && !w_s_last) begin
                  r_stage <= r_stage + 1'b1;
                  r_k     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // issue and write-back in the same cycle cancel out
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         r_out <= '0;
      else if (w_fire && !bf.wb_done)
         r_out <= r_out + 1'b1;
      else if (!w_fire && bf.wb_done && !w_drained)
         r_out <= r_out - 1'b1;
   end

   fft_addr_gen #(
      .LOG2N (LOG2N),
      .SW    (SW)
   ) u_addr_gen (
      .i_stage  (r_stage),
      .i_k      (r_k),
      .o_addr_a (w_addr_a),
      .o_addr_b (w_addr_b),
      .o_tw_idx (w_tw)
   );

   assign Busy = (r_state == S_LOAD) || w_issue
              || (r_state == S_DRAIN);
   assign Done = r_state == S_FIN;

   assign bf.bf_valid = w_issue && (r_out != CW'(MAX_OUT));
   assign bf.addr_a   = w_issue ? w_addr_a : '0;
   assign bf.addr_b   = w_issue ? w_addr_b : '0;
   assign bf.tw_idx   = w_issue ? w_tw : '0;
   assign bf.stage    = r_stage;

`ifdef FFT_SEQ_BITREV_EN
   assign ld_valid = r_state == S_LOAD;
   assign ld_addr  = ld_valid
                   ? LOG2N'(bitreverse(32'(r_n), LOG2N))
                   : '0;
`else
   assign ld_valid = 1'b0;
   assign ld_addr  = '0;
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl (LOG2N=3, MAX_OUT=2)
// against a butterfly-list reference model.
module tb_fft_seq_ctrl;
   import fft_pkg::*;

   localparam int L  = 3;
   localparam int N  = 1 << L;
   localparam int MO = 2;

   typedef struct {
      int s;
      int a;
      int b;
      int tw;
   } bf_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         busy;
   logic         done;
   logic         ld_valid;
   logic [L-1:0] ld_addr;
   int           tests = 0;
   int           fails = 0;

   fft_seq_ctrl_if #(.LOG2N(L)) bfi ();

   fft_seq_ctrl #(
      .LOG2N   (L),
      .MAX_OUT (MO)
   ) dut (
      .Clk      (clk),
      .Reset_n  (rst_n),
      .Start    (start),
      .Busy     (busy),
      .Done     (done),
      .ld_valid (ld_valid),
      .ld_addr  (ld_addr),
      .bf       (bfi)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_ldv"}, ld_valid, 0);
      chk({tag, "_ldaddr"}, ld_addr, 0);
      chk({tag, "_bfv"}, bfi.bf_valid, 0);
      chk({tag, "_a"}, bfi.addr_a, 0);
      chk({tag, "_b"}, bfi.addr_b, 0);
      chk({tag, "_tw"}, bfi.tw_idx, 0);
      chk({tag, "_stage"}, bfi.stage, 0);
   endtask

   task automatic run(input int rdy_pct, input int dmin,
                      input int dmax, input bit noise,
                      input bit spam, input int hold_wb,
                      input int stall_at, input bit rst_mid);
      bf_t  exp[$];
      bf_t  e;
      int   pend[$];
      int   mout = 0;
      int   last_s = 0;
      int   fires = 0;
      int   cyc = 0;
      int   due;
      int   last_due = 0;
      bit   rdy;
      bit   wb;
      bit   fire;
      bit   pstall = 0;
      bit   got_done = 0;
      logic [31:0] pa, pb, pt;

      // natural-order butterfly list: lower partner has bit s clear
      for (int s = 0; s < L; s++) begin
         int half;
         half = 1 << s;
         for (int j = 0; j < N; j++)
            if (((j / half) % 2) == 0)
               exp.push_back('{s, j, j + half,
                               (j % half) * (N / (2 * half))});
      end

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
`ifdef FFT_SEQ_BITREV_EN
      for (int n = 0; n < N; n++) begin
         int r;
         r = 0;
         for (int bt = 0; bt < L; bt++) r = r * 2 + ((n >> bt) & 1);
         chk("ld_valid", ld_valid, 1);
         chk("ld_addr", ld_addr, r);
         chk("ld_bfv", bfi.bf_valid, 0);
         @(negedge clk);
      end
`endif
      forever begin
         if (cyc > 400) begin
            chk("timeout_done", got_done, 1);
            break;
         end
         if (rst_mid && last_s == 1) begin
            bfi.bf_ready = 1'b0;
            bfi.wb_done  = 1'b0;
            #2 rst_n = 1'b0;
            #1 check_reset_vals("rst_async");
            @(negedge clk);
            check_reset_vals("rst_held");
            rst_n = 1'b1;
            return;
         end
         if (done) begin
            got_done = 1;
            chk("busy_at_done", busy, 0);
            chk("left_at_done", exp.size() + pend.size(), 0);
            bfi.bf_ready = 1'b0;
            bfi.wb_done  = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
               chk("done_once", done, 0);
               chk("idle_busy", busy, 0);
               @(negedge clk);
            end
            break;
         end
         chk("busy", busy, 1);
         if (pstall) begin
            chk("hold_bfv", bfi.bf_valid, 1);
            chk("hold_a", bfi.addr_a, pa);
            chk("hold_b", bfi.addr_b, pb);
            chk("hold_tw", bfi.tw_idx, pt);
         end
         if (bfi.bf_valid) chk("out_lt_max", mout < MO, 1);
         if (cyc < hold_wb && fires >= MO)
            chk("bfv_while_full", bfi.bf_valid, 0);
         if (hold_wb > 0 && cyc == hold_wb)
            chk("fires_at_hold", fires, MO);

         rdy = $urandom_range(99) < rdy_pct;
         if (cyc >= stall_at && cyc < stall_at + 5) rdy = 1'b0;
         wb = 1'b0;
         if (cyc >= hold_wb && pend.size() > 0 && pend[0] <= cyc) begin
            wb = 1'b1;
            void'(pend.pop_front());
         end
         fire = bfi.bf_valid && rdy;
         if (noise && !wb && mout == 0 && !fire
             && $urandom_range(3) == 0)
            wb = 1'b1;

         if (fire) begin
            if (exp.size() == 0) begin
               chk("extra_bf", exp.size(), 1);
            end else begin
               e = exp.pop_front();
               chk("stage", bfi.stage, e.s);
               chk("addr_a", bfi.addr_a, e.a);
               chk("addr_b", bfi.addr_b, e.b);
               chk("tw_idx", bfi.tw_idx, e.tw);
               if (e.s != last_s) chk("barrier", mout, 0);
               last_s = e.s;
               fires++;
               due = cyc + $urandom_range(dmax, dmin);
               if (due < last_due) due = last_due;
               last_due = due;
               pend.push_back(due);
            end
         end
         if (spam) start = $urandom_range(1);

         bfi.bf_ready = rdy;
         bfi.wb_done  = wb;
         if (fire && !wb)            mout++;
         else if (!fire && wb && mout > 0) mout--;

         pstall = bfi.bf_valid && !rdy;
         pa = bfi.addr_a;
         pb = bfi.addr_b;
         pt = bfi.tw_idx;
         cyc++;
         @(negedge clk);
      end
      bfi.bf_ready = 1'b0;
      bfi.wb_done  = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      bfi.bf_ready = 1'b0;
      bfi.wb_done  = 1'b0;
      #12 check_reset_vals("por");
      @(negedge clk);
      rst_n = 1'b1;

      run(100, 2, 2, 0, 0, 0, 1000, 0);
      run(100, 2, 2, 0, 0, 8, 1000, 0);
      run(100, 1, 1, 0, 0, 0, 3, 0);
      run(100, 2, 2, 0, 0, 0, 1000, 1);
      run(100, 2, 2, 0, 0, 0, 1000, 0);
      for (int i = 0; i < 6; i++)
         run($urandom_range(100, 30), 1, $urandom_range(6, 1),
             1, 1, 0, 1000, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
